// File: rtl/sipo16_zero_detect.sv
// Serial-in/parallel-out deserializer with a valid/ready word output.
// It also provides a registered all-zero flag (ZN0) for the presented word.
module sipo16_zero_detect #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CLR,
  input  logic             SI,
  input  logic             SIV,
  output logic             SIRDY,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  input  logic             QRDY,
  output logic             ZN0
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             zn0_q, zn0_d;

  logic [WIDTH-1:0] word;
  logic [CW-1:0]    bit_idx;
  logic             last_bit;
  logic             accept;

  // Only the completing bit has to wait for the held word to drain.
  assign last_bit = (cnt_q == CNT_LAST);
  assign SIRDY    = (state_q == EMPTY) || QRDY || !last_bit;
  assign accept   = SIV && SIRDY;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    zn0_d   = zn0_q;

    bit_idx       = MSB_FIRST ? (CNT_LAST - cnt_q) : cnt_q;
    word          = sr_q;
    word[bit_idx] = SI;

    if ((state_q == FULL) && QRDY) begin
      state_d = EMPTY;
    end

    // CLR wins over any accept; the last presented word stays on Q.
    if (CLR) begin
      sr_d    = '0;
      cnt_d   = '0;
      state_d = EMPTY;
    end else if (accept) begin
      if (last_bit) begin
        q_d     = word;
        zn0_d   = ~|word;
        state_d = FULL;
        cnt_d   = '0;
        sr_d    = '0;
      end else begin
        sr_d  = word;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= EMPTY;
      sr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      zn0_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      zn0_q   <= zn0_d;
    end
  end

  assign Q   = q_q;
  assign QV  = (state_q == FULL);
  assign ZN0 = zn0_q;

endmodule
